mole_scheduler: RTL and testbench
=================================

Name: mole_scheduler

Overview:
Game sequencer for the whack-a-mole board. It pops one mole at a time at a pseudo-random hole (0-8) and holds it up for a fixed window. It consumes key events from the keypad controller, scores hits against the active hole and counts misses. It sits between the keypad controller (upstream) and the LED/display drivers (downstream).

Parameters:
NUM_HOLES, 9, number of holes/keys; valid positions 0..NUM_HOLES-1
TICK_DIV, 50000, clk cycles per 1 ms tick (50 MHz)
UP_TIME_MS, 1000, mole visible window in ms
GAP_TIME_MS, 300, blank time between moles in ms
ROUND_MOLES, 20, moles per round
LFSR_SEED, 8'hA5, LFSR reset value; must be non-zero

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
start  input  1  level; sampled only in IDLE; begins a round
valid_key  input  1  key-valid level from keypad controller
key  input  4  position of pressed key (0-8)
mole_mask  output  9  one-hot active mole; all zero when no mole is up
mole_pos  output  4  index of active/last mole
score  output  8  hits this round, saturating at 255
misses  output  8  wrong keys plus timeouts, saturating at 255
busy  output  1  high in every state except IDLE
hit_pulse  output  1  one-cycle pulse on a correct hit
round_done  output  1  one-cycle pulse when the round ends

Behaviour:
- Reset (async assert, synchronous release): state IDLE. mole_mask=0, mole_pos=0, score=0, misses=0, busy=0, both pulses 0, LFSR=LFSR_SEED, all counters 0.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every clk cycle in all states.
- Key event: a rising edge of valid_key, detected against a 1-cycle registered copy. Events with key >= NUM_HOLES are discarded. Events outside UP are discarded.
- FSM states:
  - IDLE: on start=1, clear score, misses and the mole count, then go to PICK next cycle. score and misses otherwise hold their last round values.
  - PICK: cand=lfsr[3:0]. Accept cand if cand < NUM_HOLES and cand != mole_pos; on accept, load mole_pos, go to UP. Otherwise retry next cycle. After 8 rejected cycles, force mole_pos=(mole_pos+1) mod NUM_HOLES. Worst-case PICK latency is 9 cycles.
  - UP: mole_mask = 1<<mole_pos.
    - Key event with key==mole_pos: score+1, hit_pulse, go to GAP.
    - Key event with another key: misses+1, stay in UP, timer not restarted.
    - Timer expiry: misses+1, go to GAP.
    - Hit and expiry in the same cycle: the hit wins, misses unchanged.
  - GAP: mole_mask=0. After GAP_TIME_MS ms, increment the mole count. If count==ROUND_MOLES go to DONE, else go to PICK.
  - DONE: round_done=1 for exactly one cycle, then go to IDLE. busy=0 from IDLE onward.
- Timing: a prescaler counts 0..TICK_DIV-1 and a ms counter counts ticks. Both clear on entry to UP and to GAP. UP lasts exactly UP_TIME_MS*TICK_DIV cycles with no hit. GAP lasts exactly GAP_TIME_MS*TICK_DIV cycles.
- Saturation: score and misses stop at 8'hFF and never wrap.
- start while busy: ignored; the round continues.
- Reset mid-round: immediate return to reset values; no round_done is issued.
- valid_key held high across the entry to UP: no event is generated; a release and re-press is required.
- All outputs are registered.

Decomposition:
- Shared package wam_pkg:
  - state enum (IDLE, PICK, UP, GAP, DONE)
  - NUM_HOLES, KEY_W=4, SCORE_W=8
  - LFSR tap constant
- One sub-module: mole_lfsr (8-bit LFSR; enable and seed parameter; reset to seed).
- Prescaler, ms timer and FSM stay in mole_scheduler.

Test Plan:
Bench parameters for every scenario: TICK_DIV=4, UP_TIME_MS=5, GAP_TIME_MS=2, ROUND_MOLES=3.
- Reset: pulse reset low mid-UP -> all outputs 0 and busy=0 within the same cycle; after release, start launches a new round with score=0.
- Hit: start; in UP press key=mole_pos -> hit_pulse for 1 cycle, score=1, mole_mask=0 next cycle, GAP lasts 8 cycles.
- Wrong key then timeout: press (mole_pos+1)%9, no further input -> misses=1 right after the press, UP lasts 20 cycles total, then misses=2.
- Simultaneous: press the correct key on the exact expiry cycle -> score=1, misses=0.
- Full round: 3 moles, hit each -> successive mole_pos values all differ and are <9; round_done pulses once; busy falls; score=3 holds until the next start.
- Ignored inputs: key=12 in UP; key press during GAP; start during UP; valid_key held high into UP -> no change to score or misses, round unaffected.

Source files
------------

// File: rtl/wam_pkg.sv
// Shared types and constants for the whack-a-mole sequencer.
// Holds the FSM state encoding, board geometry, LFSR taps and a saturating increment helper.
package wam_pkg;

  localparam int NUM_HOLES = 9;
  localparam int KEY_W     = 4;
  localparam int SCORE_W   = 8;
  localparam int LFSR_W    = 8;

  // x^8 + x^6 + x^5 + x^4 + 1 in shift-left form: feedback from bits 7,5,4,3
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {IDLE, PICK, UP, GAP, DONE} state_t;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == {SCORE_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 8-bit Fibonacci LFSR used to pick the next mole hole.
// Shifts left with XOR feedback on every enabled cycle and reloads SEED on reset.
module mole_lfsr
  import wam_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [LFSR_W-1:0] lfsr
);

  logic [LFSR_W-1:0] lfsr_reg;
  logic [LFSR_W-1:0] lfsr_next;
  logic              feedback;

  always_comb begin
    feedback  = ^(lfsr_reg & LFSR_TAPS);
    lfsr_next = en ? {lfsr_reg[LFSR_W-2:0], feedback} : lfsr_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_reg <= SEED;
    else        lfsr_reg <= lfsr_next;
  end

  assign lfsr = lfsr_reg;

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole round sequencer: picks holes, times the up/gap windows,
// scores key events against the active hole and counts misses.
module mole_scheduler
  import wam_pkg::*;
#(
  parameter int                TICK_DIV    = 50000,
  parameter int                UP_TIME_MS  = 1000,
  parameter int                GAP_TIME_MS = 300,
  parameter int                ROUND_MOLES = 20,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 valid_key,
  input  logic [KEY_W-1:0]     key,
  output logic [NUM_HOLES-1:0] mole_mask,
  output logic [KEY_W-1:0]     mole_pos,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   misses,
  output logic                 busy,
  output logic                 hit_pulse,
  output logic                 round_done
);

  localparam int PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MS_MAX     = (UP_TIME_MS > GAP_TIME_MS) ? UP_TIME_MS : GAP_TIME_MS;
  localparam int MS_W       = $clog2(MS_MAX + 1);
  localparam int CNT_W      = $clog2(ROUND_MOLES + 1);
  localparam int PICK_TRIES = 8;

  state_t               state_reg, state_next;
  logic [PRESC_W-1:0]   presc_reg, presc_next;
  logic [MS_W-1:0]      ms_reg, ms_next;
  logic [3:0]           pick_cnt_reg, pick_cnt_next;
  logic [CNT_W-1:0]     mole_cnt_reg, mole_cnt_next;
  logic [KEY_W-1:0]     mole_pos_reg, mole_pos_next;
  logic [SCORE_W-1:0]   score_reg, score_next;
  logic [SCORE_W-1:0]   misses_reg, misses_next;
  logic [NUM_HOLES-1:0] mole_mask_reg, mole_mask_next;
  logic [NUM_HOLES-1:0] pos_onehot;
  logic                 busy_reg, busy_next;
  logic                 hit_reg, hit_next;
  logic                 done_reg, done_next;
  logic                 valid_key_reg;

  logic [LFSR_W-1:0]    lfsr;
  logic                 lfsr_hi_unused;
  logic [KEY_W-1:0]     cand;
  logic [KEY_W-1:0]     pos_inc;
  logic                 key_event, hit, wrong;
  logic                 tick_wrap, timer_done, cand_ok, pick_force, entering_timed;

  mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .lfsr  (lfsr)
  );

  assign lfsr_hi_unused = ^lfsr[LFSR_W-1:KEY_W];
  assign cand           = lfsr[KEY_W-1:0];
  assign cand_ok        = (cand < KEY_W'(NUM_HOLES)) && (cand != mole_pos_reg);
  assign pick_force     = (pick_cnt_reg == 4'(PICK_TRIES));
  assign pos_inc        = (mole_pos_reg == KEY_W'(NUM_HOLES - 1)) ? '0 : mole_pos_reg + 1'b1;

  // Only a fresh press of an on-board key while the mole is up counts.
  assign key_event = valid_key && !valid_key_reg && (key < KEY_W'(NUM_HOLES)) && (state_reg == UP);
  assign hit       = key_event && (key == mole_pos_reg);
  assign wrong     = key_event && !hit;

  assign tick_wrap  = (presc_reg == PRESC_W'(TICK_DIV - 1));
  assign timer_done = tick_wrap &&
                      (((state_reg == UP)  && (ms_reg == MS_W'(UP_TIME_MS - 1))) ||
                       ((state_reg == GAP) && (ms_reg == MS_W'(GAP_TIME_MS - 1))));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = PICK;
      PICK: if (cand_ok || pick_force) state_next = UP;
      UP:   if (hit || timer_done) state_next = GAP;
      GAP:  if (timer_done)
              state_next = (mole_cnt_reg == CNT_W'(ROUND_MOLES - 1)) ? DONE : PICK;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mole_pos_next = mole_pos_reg;
    if (state_reg == PICK) begin
      if (cand_ok)         mole_pos_next = cand;
      else if (pick_force) mole_pos_next = pos_inc;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_HOLES; gi++) begin : g_onehot
      assign pos_onehot[gi] = (mole_pos_next == KEY_W'(gi));
    end
  endgenerate

  assign entering_timed = (state_next != state_reg) && ((state_next == UP) || (state_next == GAP));

  always_comb begin
    presc_next     = presc_reg;
    ms_next        = ms_reg;
    pick_cnt_next  = '0;
    mole_cnt_next  = mole_cnt_reg;
    score_next     = score_reg;
    misses_next    = misses_reg;
    mole_mask_next = (state_next == UP) ? pos_onehot : '0;
    busy_next      = (state_next != IDLE);
    hit_next       = hit;
    done_next      = (state_next == DONE);

    if (entering_timed) begin
      presc_next = '0;
      ms_next    = '0;
    end else if ((state_reg == UP) || (state_reg == GAP)) begin
      if (tick_wrap) begin
        presc_next = '0;
        ms_next    = ms_reg + 1'b1;
      end else begin
        presc_next = presc_reg + 1'b1;
      end
    end

    case (state_reg)
      IDLE: if (start) begin
        score_next    = '0;
        misses_next   = '0;
        mole_cnt_next = '0;
      end
      PICK: if (state_next == PICK) pick_cnt_next = pick_cnt_reg + 1'b1;
      // A hit on the expiry cycle takes priority over the timeout miss.
      UP: begin
        if (hit)                       score_next  = sat_inc(score_reg);
        else if (wrong || timer_done)  misses_next = sat_inc(misses_reg);
      end
      GAP: if (timer_done) mole_cnt_next = mole_cnt_reg + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_reg     <= '0;
      ms_reg        <= '0;
      pick_cnt_reg  <= '0;
      mole_cnt_reg  <= '0;
      mole_pos_reg  <= '0;
      score_reg     <= '0;
      misses_reg    <= '0;
      mole_mask_reg <= '0;
      busy_reg      <= 1'b0;
      hit_reg       <= 1'b0;
      done_reg      <= 1'b0;
      valid_key_reg <= 1'b0;
    end else begin
      presc_reg     <= presc_next;
      ms_reg        <= ms_next;
      pick_cnt_reg  <= pick_cnt_next;
      mole_cnt_reg  <= mole_cnt_next;
      mole_pos_reg  <= mole_pos_next;
      score_reg     <= score_next;
      misses_reg    <= misses_next;
      mole_mask_reg <= mole_mask_next;
      busy_reg      <= busy_next;
      hit_reg       <= hit_next;
      done_reg      <= done_next;
      valid_key_reg <= valid_key;
    end
  end

  assign mole_mask  = mole_mask_reg;
  assign mole_pos   = mole_pos_reg;
  assign score      = score_reg;
  assign misses     = misses_reg;
  assign busy       = busy_reg;
  assign hit_pulse  = hit_reg;
  assign round_done = done_reg;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler with a short tick: 4-cycle ms, 5 ms up, 2 ms gap, 3 moles.
`timescale 1ns/1ps
module tb_mole_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       valid_key = 1'b0;
  logic [3:0] key = 4'd0;
  logic [8:0] mole_mask;
  logic [3:0] mole_pos;
  logic [7:0] score, misses;
  logic       busy, hit_pulse, round_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mole_scheduler #(
    .TICK_DIV(4), .UP_TIME_MS(5), .GAP_TIME_MS(2), .ROUND_MOLES(3), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .valid_key(valid_key), .key(key),
    .mole_mask(mole_mask), .mole_pos(mole_pos), .score(score), .misses(misses),
    .busy(busy), .hit_pulse(hit_pulse), .round_done(round_done)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_up(input string tag);
    int n = 0;
    while (mole_mask == '0 && n < 40) begin
      step();
      n++;
    end
    check_eq(tag, int'(mole_mask != '0), 1);
  endtask

  task automatic press(input logic [3:0] k);
    valid_key = 1'b1;
    key       = k;
    step();
    $display("press key=%0d pos=%0d -> score=%0d misses=%0d hit=%0d",
             k, mole_pos, score, misses, hit_pulse);
  endtask

  task automatic release_key();
    valid_key = 1'b0;
    step();
  endtask

  logic [3:0] pos, prev, wrong_key;
  int n;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mask", int'(mole_mask), 0);
    check_eq("rst_pos", int'(mole_pos), 0);
    check_eq("rst_score", int'(score), 0);
    check_eq("rst_misses", int'(misses), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_hit", int'(hit_pulse), 0);
    check_eq("rst_done", int'(round_done), 0);
    reset = 1'b1;
    step();
    step();

    // Round A: hit every mole
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("a_busy_start", int'(busy), 1);
    prev = 4'd0;
    for (int m = 0; m < 3; m++) begin
      wait_up("a_up");
      pos = mole_pos;
      check_eq("a_pos_range", int'(pos < 4'd9), 1);
      check_eq("a_pos_differs", int'(pos != prev), 1);
      check_eq("a_mask", int'(mole_mask), 1 << pos);
      if (m == 0) begin
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("a_start_in_up_busy", int'(busy), 1);
        check_eq("a_start_in_up_mask", int'(mole_mask), 1 << pos);
      end
      press(pos);
      check_eq("a_hit_pulse", int'(hit_pulse), 1);
      check_eq("a_score", int'(score), m + 1);
      check_eq("a_mask_cleared", int'(mole_mask), 0);
      release_key();
      check_eq("a_hit_one_cycle", int'(hit_pulse), 0);
      prev = pos;
    end
    // Last gap is 8 cycles, then DONE
    n = 1;
    while (!round_done && n < 20) begin
      step();
      n++;
    end
    check_eq("a_gap_len", n, 8);
    check_eq("a_done", int'(round_done), 1);
    check_eq("a_busy_in_done", int'(busy), 1);
    step();
    check_eq("a_done_one_cycle", int'(round_done), 0);
    check_eq("a_busy_idle", int'(busy), 0);
    check_eq("a_score_final", int'(score), 3);
    repeat (5) step();
    check_eq("a_score_hold", int'(score), 3);
    check_eq("a_done_quiet", int'(round_done), 0);

    // Round B: wrong key then timeout, then ignored inputs
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("b_score_cleared", int'(score), 0);
    wait_up("b_up1");
    pos       = mole_pos;
    wrong_key = 4'((int'(pos) + 1) % 9);
    press(wrong_key);
    check_eq("b_miss_wrong", int'(misses), 1);
    check_eq("b_still_up", int'(mole_mask), 1 << pos);
    release_key();
    n = 2;
    while (mole_mask != '0 && n < 40) begin
      step();
      n++;
    end
    check_eq("b_up_len", n, 20);
    check_eq("b_miss_timeout", int'(misses), 2);
    check_eq("b_score_zero", int'(score), 0);
    // Press during GAP and keep it held into the next UP
    valid_key = 1'b1;
    key       = 4'd0;
    step();
    check_eq("b_gap_press", int'(misses), 2);
    wait_up("b_up2");
    pos = mole_pos;
    key = pos;
    step();
    check_eq("b_held_score", int'(score), 0);
    check_eq("b_held_misses", int'(misses), 2);
    valid_key = 1'b0;
    step();
    press(4'd12);
    check_eq("b_badkey_misses", int'(misses), 2);
    check_eq("b_badkey_score", int'(score), 0);
    release_key();
    press(pos);
    check_eq("b_hit2_score", int'(score), 1);
    release_key();
    wait_up("b_up3");
    pos = mole_pos;
    press(pos);
    check_eq("b_hit3_score", int'(score), 2);
    release_key();
    n = 0;
    while (!round_done && n < 40) begin
      step();
      n++;
    end
    check_eq("b_done", int'(round_done), 1);
    check_eq("b_final_score", int'(score), 2);
    check_eq("b_final_misses", int'(misses), 2);

    // Round C: hit on the exact expiry cycle
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_up("c_up");
    pos = mole_pos;
    repeat (19) step();
    check_eq("c_last_up_cycle", int'(mole_mask), 1 << pos);
    press(pos);
    check_eq("c_sim_score", int'(score), 1);
    check_eq("c_sim_misses", int'(misses), 0);
    check_eq("c_sim_hit", int'(hit_pulse), 1);
    check_eq("c_sim_mask", int'(mole_mask), 0);
    release_key();

    // Reset mid-UP
    wait_up("c_up2");
    repeat (3) step();
    reset = 1'b0;
    #2;
    check_eq("d_rst_mask", int'(mole_mask), 0);
    check_eq("d_rst_pos", int'(mole_pos), 0);
    check_eq("d_rst_score", int'(score), 0);
    check_eq("d_rst_misses", int'(misses), 0);
    check_eq("d_rst_busy", int'(busy), 0);
    check_eq("d_rst_hit", int'(hit_pulse), 0);
    step();
    check_eq("d_rst_no_done", int'(round_done), 0);
    reset = 1'b1;
    step();
    step();
    check_eq("d_idle_busy", int'(busy), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_up("d_up");
    check_eq("d_new_busy", int'(busy), 1);
    check_eq("d_new_score", int'(score), 0);
    check_eq("d_new_misses", int'(misses), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
